// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// Module   : master_port
// Brief    : Device-side request port that wins the bus, shifts address and
//            write data out serially, and collects serial read data.
// Revision : 1.0  initial release
// ============================================================================

module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,   // must be >= 2
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derror,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  srdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);

    localparam int SW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_ADDR_END = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] c_XFER_END = CW'(SW);
    localparam logic [CW-1:0] c_RD_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_START = 3'd2,
        S_ADDR  = 3'd3,
        S_WDATA = 3'd4,
        S_RWAIT = 3'd5,
        S_RDATA = 3'd6,
        S_WACK  = 3'd7
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [SW-1:0]         r_shift;
    logic [CW-1:0]         r_bcnt;
    logic [TW-1:0]         r_tcnt;
    logic [DATA_WIDTH-2:0] r_rbuf;
    logic [DATA_WIDTH-1:0] r_drdata;
    logic                  r_ddone;
    logic                  r_derror;
    logic                  r_mbreq;
    logic                  r_mvalid;
    logic                  r_mwdata;
    logic                  r_mmode;

    logic [DATA_WIDTH-1:0] w_rword;
    logic                  w_to_last;

    // Newest serial bit enters at the top so the first bit lands in bit 0.
    assign w_rword   = {srdata, r_rbuf};
    assign w_to_last = (r_tcnt == c_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_shift  <= '0;
            r_bcnt   <= '0;
            r_tcnt   <= '0;
            r_rbuf   <= '0;
            r_drdata <= '0;
            r_ddone  <= 1'b0;
            r_derror <= 1'b0;
            r_mbreq  <= 1'b0;
            r_mvalid <= 1'b0;
            r_mwdata <= 1'b0;
            r_mmode  <= 1'b0;
        end else if (r_ddone) begin
            // Completion cycle: release the bus one cycle after ddone.
            r_ddone  <= 1'b0;
            r_derror <= 1'b0;
            r_mbreq  <= 1'b0;
            r_state  <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dvalid) begin
                        r_mode  <= dmode;
                        r_shift <= {dwdata, daddr};
                        r_mbreq <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mbgrant) begin
                        r_tcnt  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (sready) begin
                        r_mvalid <= 1'b1;
                        r_mmode  <= r_mode;
                        r_mwdata <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bcnt   <= CW'(1);
                        r_state  <= S_ADDR;
                    end else if (!ssplit) begin
                        if (w_to_last) begin
                            r_ddone  <= 1'b1;
                            r_derror <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (r_bcnt == c_ADDR_END && !r_mode) begin
                        r_mvalid <= 1'b0;
                        r_mwdata <= 1'b0;
                        r_mmode  <= 1'b0;
                        r_tcnt   <= '0;
                        r_bcnt   <= '0;
                        r_state  <= S_RWAIT;
                    end else begin
                        r_mwdata <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bcnt   <= r_bcnt + 1'b1;
                        if (r_bcnt == c_ADDR_END) begin
                            r_state <= S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (r_bcnt == c_XFER_END) begin
                        r_mvalid <= 1'b0;
                        r_mwdata <= 1'b0;
                        r_mmode  <= 1'b0;
                        r_tcnt   <= '0;
                        r_bcnt   <= '0;
                        r_state  <= S_WACK;
                    end else begin
                        r_mwdata <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bcnt   <= r_bcnt + 1'b1;
                    end
                end
                S_RWAIT: begin
                    if (svalid) begin
                        r_rbuf  <= w_rword[DATA_WIDTH-1:1];
                        r_bcnt  <= CW'(1);
                        r_state <= S_RDATA;
                    end else if (!ssplit) begin
                        if (w_to_last) begin
                            r_ddone  <= 1'b1;
                            r_derror <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_RDATA: begin
                    if (svalid) begin
                        r_rbuf <= w_rword[DATA_WIDTH-1:1];
                        r_bcnt <= r_bcnt + 1'b1;
                        if (r_bcnt == c_RD_LAST) begin
                            r_drdata <= w_rword;
                            r_ddone  <= 1'b1;
                        end
                    end
                end
                S_WACK: begin
                    if (sready) begin
                        r_ddone <= 1'b1;
                    end else if (!ssplit) begin
                        if (w_to_last) begin
                            r_ddone  <= 1'b1;
                            r_derror <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dready = (r_state == S_IDLE) && !rst;
    assign drdata = r_drdata;
    assign ddone  = r_ddone;
    assign derror = r_derror;
    assign mbreq  = r_mbreq;
    assign mwdata = r_mwdata;
    assign mmode  = r_mmode;
    assign mvalid = r_mvalid;

endmodule

`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_port
// Brief    : Directed self-checking bench for master_port.
// Revision : 1.0  initial release
// ============================================================================

module tb_master_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        dvalid;
    logic        dready;
    logic        dmode;
    logic [11:0] daddr;
    logic [7:0]  dwdata;
    logic [7:0]  drdata;
    logic        ddone;
    logic        derror;
    logic        mbreq;
    logic        mbgrant;
    logic        mwdata;
    logic        mmode;
    logic        mvalid;
    logic        srdata;
    logic        svalid;
    logic        sready;
    logic        ssplit;

    int checks = 0;
    int errors = 0;

    master_port #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .TIMEOUT   (64)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .dvalid (dvalid),
        .dready (dready),
        .dmode  (dmode),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .ddone  (ddone),
        .derror (derror),
        .mbreq  (mbreq),
        .mbgrant(mbgrant),
        .mwdata (mwdata),
        .mmode  (mmode),
        .mvalid (mvalid),
        .srdata (srdata),
        .svalid (svalid),
        .sready (sready),
        .ssplit (ssplit)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a request, hold off the grant for gdelay cycles, end in START.
    task automatic start_txn(input logic mode, input logic [11:0] addr,
                             input logic [7:0] wdata, input int gdelay);
        dvalid = 1'b1;
        dmode  = mode;
        daddr  = addr;
        dwdata = wdata;
        tick;
        dvalid = 1'b0;
        repeat (gdelay) tick;
        mbgrant = 1'b1;
        tick;
        mbgrant = 1'b0;
    endtask

    // Record mwdata while mvalid is high; returns on the first low cycle after.
    task automatic capture_serial(input bit drop_sready, output int n,
                                  output logic [31:0] bits, output int mode_ones,
                                  output bit timed_out);
        n         = 0;
        bits      = '0;
        mode_ones = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (mvalid) begin
                if (n < 32) bits[n] = mwdata;
                mode_ones += int'(mmode);
                n++;
                if (drop_sready) sready = 1'b0;
            end else if (n > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) tick;
        checks++;
        if (dready !== 1'b0 || mbreq !== 1'b0 || mvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: dready=%b mbreq=%b mvalid=%b, required 0 0 0", dready, mbreq, mvalid);
        end
        checks++;
        if (mwdata !== 1'b0 || mmode !== 1'b0 || ddone !== 1'b0 || derror !== 1'b0 || drdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: mwdata=%b mmode=%b ddone=%b derror=%b drdata=%h, required all 0",
                     mwdata, mmode, ddone, derror, drdata);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (dready !== 1'b1 || mbreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: dready=%b mbreq=%b, required 1 0", dready, mbreq);
        end
    endtask

    task automatic test_write;
        int          n;
        int          mones;
        bit          to;
        bit          early;
        logic [31:0] bits;
        logic [19:0] exp_stream;
        exp_stream = 20'h3BA5C;
        sready = 1'b1;
        dvalid = 1'b1;
        dmode  = 1'b1;
        daddr  = 12'hA5C;
        dwdata = 8'h3B;
        tick;
        dvalid = 1'b0;
        checks++;
        if (mbreq !== 1'b1 || dready !== 1'b0) begin
            errors++;
            $display("FAIL wr_accept: mbreq=%b dready=%b, required 1 0", mbreq, dready);
        end
        tick;
        tick;
        checks++;
        if (mbreq !== 1'b1 || mvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait_grant: mbreq=%b mvalid=%b, required 1 0", mbreq, mvalid);
        end
        mbgrant = 1'b1;
        tick;
        mbgrant = 1'b0;
        capture_serial(1'b1, n, bits, mones, to);
        checks++;
        if (to || n != 20) begin
            errors++;
            $display("FAIL wr_mvalid_len: cycles=%0d timeout=%b, required 20 0", n, to);
        end
        checks++;
        if (bits[19:0] !== exp_stream) begin
            errors++;
            $display("FAIL wr_stream: got %h, required %h", bits[19:0], exp_stream);
        end
        checks++;
        if (mones != 20) begin
            errors++;
            $display("FAIL wr_mmode: mmode high %0d cycles, required 20", mones);
        end
        early = 1'b0;
        repeat (5) begin
            tick;
            if (ddone !== 1'b0 || mbreq !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL wr_wack_hold: early ddone or mbreq drop=%b, required 0", early);
        end
        sready = 1'b1;
        tick;
        checks++;
        if (ddone !== 1'b1 || derror !== 1'b0 || mbreq !== 1'b1) begin
            errors++;
            $display("FAIL wr_done: ddone=%b derror=%b mbreq=%b, required 1 0 1", ddone, derror, mbreq);
        end
        tick;
        checks++;
        if (ddone !== 1'b0 || mbreq !== 1'b0 || dready !== 1'b1) begin
            errors++;
            $display("FAIL wr_after: ddone=%b mbreq=%b dready=%b, required 0 0 1", ddone, mbreq, dready);
        end
    endtask

    task automatic test_read;
        int          n;
        int          mones;
        bit          to;
        bit          early;
        logic [31:0] bits;
        logic [7:0]  v;
        v = 8'h96;
        sready = 1'b1;
        start_txn(1'b0, 12'h001, 8'h00, 1);
        capture_serial(1'b0, n, bits, mones, to);
        checks++;
        if (to || n != 12 || bits[11:0] !== 12'h001) begin
            errors++;
            $display("FAIL rd_addr: cycles=%0d bits=%h timeout=%b, required 12 001 0", n, bits[11:0], to);
        end
        checks++;
        if (mones != 0) begin
            errors++;
            $display("FAIL rd_mmode: mmode high %0d cycles, required 0", mones);
        end
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            svalid = 1'b1;
            srdata = v[i];
            tick;
            svalid = 1'b0;
            if (i < 7 && (ddone !== 1'b0 || drdata !== 8'h00)) early = 1'b1;
            if (i == 3) begin
                tick;
                if (ddone !== 1'b0) early = 1'b1;
            end
        end
        checks++;
        if (ddone !== 1'b1 || derror !== 1'b0 || drdata !== 8'h96 || early) begin
            errors++;
            $display("FAIL rd_done: ddone=%b derror=%b drdata=%h early=%b, required 1 0 96 0",
                     ddone, derror, drdata, early);
        end
        tick;
        checks++;
        if (ddone !== 1'b0 || mbreq !== 1'b0) begin
            errors++;
            $display("FAIL rd_after: ddone=%b mbreq=%b, required 0 0", ddone, mbreq);
        end
    endtask

    task automatic test_split_read;
        int          n;
        int          mones;
        bit          to;
        bit          early;
        logic [31:0] bits;
        logic [7:0]  v;
        v = 8'h5A;
        start_txn(1'b0, 12'h7FF, 8'h00, 0);
        capture_serial(1'b0, n, bits, mones, to);
        checks++;
        if (to || n != 12 || bits[11:0] !== 12'h7FF) begin
            errors++;
            $display("FAIL split_addr: cycles=%0d bits=%h timeout=%b, required 12 7ff 0", n, bits[11:0], to);
        end
        ssplit = 1'b1;
        early = 1'b0;
        repeat (100) begin
            tick;
            if (ddone !== 1'b0) early = 1'b1;
        end
        ssplit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            svalid = 1'b1;
            srdata = v[i];
            tick;
            if (i < 7 && ddone !== 1'b0) early = 1'b1;
        end
        svalid = 1'b0;
        checks++;
        if (ddone !== 1'b1 || derror !== 1'b0 || drdata !== 8'h5A || early) begin
            errors++;
            $display("FAIL split_done: ddone=%b derror=%b drdata=%h early=%b, required 1 0 5a 0",
                     ddone, derror, drdata, early);
        end
        tick;
    endtask

    task automatic test_timeout;
        int          n;
        int          mones;
        bit          to;
        bit          early;
        logic [31:0] bits;
        start_txn(1'b0, 12'h123, 8'h00, 2);
        capture_serial(1'b0, n, bits, mones, to);
        checks++;
        if (to || n != 12) begin
            errors++;
            $display("FAIL to_addr: cycles=%0d timeout=%b, required 12 0", n, to);
        end
        early = 1'b0;
        repeat (63) begin
            tick;
            if (ddone !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL to_early: ddone before cycle 64=%b, required 0", early);
        end
        tick;
        checks++;
        if (ddone !== 1'b1 || derror !== 1'b1 || drdata !== 8'h5A) begin
            errors++;
            $display("FAIL to_done: ddone=%b derror=%b drdata=%h, required 1 1 5a", ddone, derror, drdata);
        end
        tick;
        checks++;
        if (ddone !== 1'b0 || derror !== 1'b0 || mbreq !== 1'b0) begin
            errors++;
            $display("FAIL to_after: ddone=%b derror=%b mbreq=%b, required 0 0 0", ddone, derror, mbreq);
        end
    endtask

    task automatic test_reset_mid_addr;
        int          n;
        int          mones;
        bit          to;
        bit          found;
        logic [31:0] bits;
        start_txn(1'b1, 12'hA5C, 8'h3B, 0);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (mvalid) n++;
            if (n == 6) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_reach: address bit 5 seen=%b, required 1", found);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mvalid !== 1'b0 || mbreq !== 1'b0 || dready !== 1'b0 || drdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async: mvalid=%b mbreq=%b dready=%b drdata=%h, required 0 0 0 00",
                     mvalid, mbreq, dready, drdata);
        end
        tick;
        tick;
        rst    = 1'b0;
        dvalid = 1'b1;
        dmode  = 1'b1;
        daddr  = 12'h0F0;
        dwdata = 8'hC3;
        tick;
        dvalid = 1'b0;
        checks++;
        if (mbreq !== 1'b1 || ddone !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_accept: mbreq=%b ddone=%b, required 1 0", mbreq, ddone);
        end
        mbgrant = 1'b1;
        tick;
        mbgrant = 1'b0;
        capture_serial(1'b0, n, bits, mones, to);
        checks++;
        if (to || n != 20 || bits[19:0] !== 20'hC30F0) begin
            errors++;
            $display("FAIL rst_next_stream: cycles=%0d bits=%h, required 20 c30f0", n, bits[19:0]);
        end
        tick;
        checks++;
        if (ddone !== 1'b1 || derror !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_done: ddone=%b derror=%b, required 1 0", ddone, derror);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int   overlap;
        int   nodrop;
        int   rises;
        int   dones;
        logic prev_mbreq;
        logic prev_ddone;
        bit   idle_seen;
        overlap    = 0;
        nodrop     = 0;
        rises      = 0;
        dones      = 0;
        prev_mbreq = mbreq;
        prev_ddone = ddone;
        dvalid  = 1'b1;
        dmode   = 1'b1;
        daddr   = 12'h055;
        dwdata  = 8'hAA;
        mbgrant = 1'b1;
        sready  = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick;
            if (mbreq && dready) overlap++;
            if (prev_ddone && mbreq) nodrop++;
            if (mbreq && !prev_mbreq) rises++;
            if (ddone) dones++;
            prev_mbreq = mbreq;
            prev_ddone = ddone;
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL b2b_ignore: dready high while busy %0d cycles, required 0", overlap);
        end
        checks++;
        if (nodrop != 0) begin
            errors++;
            $display("FAIL b2b_mbreq_drop: mbreq high after ddone %0d times, required 0", nodrop);
        end
        checks++;
        if (dones != 4 || rises != 5) begin
            errors++;
            $display("FAIL b2b_count: ddone=%0d mbreq_rises=%0d, required 4 5", dones, rises);
        end
        dvalid  = 1'b0;
        mbgrant = 1'b0;
        idle_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (dready && !mbreq) begin
                idle_seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!idle_seen) begin
            errors++;
            $display("FAIL b2b_drain: idle reached=%b, required 1", idle_seen);
        end
    endtask

    initial begin
        rst     = 1'b1;
        dvalid  = 1'b0;
        dmode   = 1'b0;
        daddr   = '0;
        dwdata  = '0;
        mbgrant = 1'b0;
        srdata  = 1'b0;
        svalid  = 1'b0;
        sready  = 1'b1;
        ssplit  = 1'b0;
        test_reset;
        test_write;
        test_read;
        test_split_read;
        test_timeout;
        test_reset_mid_addr;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
